// File: rtl/ctrl_pipe_pkg.sv
// Shared widths and control-bundle types for the pipeline control shadow registers.
//   EX_W / M_W / WB_W : widths of the EX, M and WB control bundles from the Controller.
//   CNT_W             : width of the retired/bubble statistics counters.
package ctrl_pipe_pkg;

    localparam int unsigned EX_W  = 9;
    localparam int unsigned M_W   = 5;
    localparam int unsigned WB_W  = 4;
    localparam int unsigned CNT_W = 16;

    typedef logic [EX_W-1:0]  ex_ctrl_t;
    typedef logic [M_W-1:0]   m_ctrl_t;
    typedef logic [WB_W-1:0]  wb_ctrl_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CntMax = '1;

    // ID/EX carries every bundle still needed downstream.
    typedef struct packed {
        ex_ctrl_t ex;
        m_ctrl_t  m;
        wb_ctrl_t wb;
        logic     valid;
    } idex_t;

    typedef struct packed {
        m_ctrl_t  m;
        wb_ctrl_t wb;
        logic     valid;
    } exmem_t;

    typedef struct packed {
        wb_ctrl_t wb;
        logic     valid;
    } memwb_t;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline control register with synchronous active-low reset and bubble load.
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous active-low reset, clears the register
//   bubble_i : load all-zero instead of d_i (valid and all control bits cleared)
//   d_i      : next stage contents
//   q_o      : registered stage contents
module ctrl_stage_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             bubble_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_d, q_q;

    always_comb begin
        q_d = d_i;
        if (bubble_i) begin
            q_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline for a 5-stage core: carries EX/M/WB bundles from ID through
// ID/EX, EX/MEM and MEM/WB, inserts bubbles on Stall/Flush and keeps saturating
// statistics counters.
//   Clk, Rst               : clock and synchronous active-low reset
//   EX_In, M_In, WB_In     : control bundles from the Controller (ID stage)
//   Valid_In               : ID holds a real instruction
//   Stall                  : load-use hazard, bubble into ID/EX
//   Flush                  : taken branch, bubble into ID/EX and EX/MEM (wins over Stall)
//   EX_Ctrl, M_Ctrl, WB_Ctrl : bundles held in ID/EX, EX/MEM, MEM/WB
//   EX_Valid, MEM_Valid, WB_Valid : per-stage valid
//   Retired, Bubbles       : saturating counts of retirements and bubble cycles
module ctrl_pipe
    import ctrl_pipe_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst,
    input  logic [EX_W-1:0] EX_In,
    input  logic [M_W-1:0]  M_In,
    input  logic [WB_W-1:0] WB_In,
    input  logic            Valid_In,
    input  logic            Stall,
    input  logic            Flush,
    output logic [EX_W-1:0] EX_Ctrl,
    output logic [M_W-1:0]  M_Ctrl,
    output logic [WB_W-1:0] WB_Ctrl,
    output logic            EX_Valid,
    output logic            MEM_Valid,
    output logic            WB_Valid,
    output logic [15:0]     Retired,
    output logic [15:0]     Bubbles
);

    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;
    cnt_t   retired_d, retired_q;
    cnt_t   bubbles_d, bubbles_q;

    logic   bubble_cycle;

    // Flush already zeroes ID/EX, so OR-ing with Stall gives the Flush-priority result.
    assign bubble_cycle = Stall | Flush;

    assign idex_d  = '{ex: EX_In, m: M_In, wb: WB_In, valid: Valid_In};
    assign exmem_d = '{m: idex_q.m, wb: idex_q.wb, valid: idex_q.valid};
    assign memwb_d = '{wb: exmem_q.wb, valid: exmem_q.valid};

    ctrl_stage_reg #(
        .Width ($bits(idex_t))
    ) u_idex (
        .clk_i    (Clk),
        .rst_ni   (Rst),
        .bubble_i (bubble_cycle),
        .d_i      (idex_d),
        .q_o      (idex_q)
    );

    ctrl_stage_reg #(
        .Width ($bits(exmem_t))
    ) u_exmem (
        .clk_i    (Clk),
        .rst_ni   (Rst),
        .bubble_i (Flush),
        .d_i      (exmem_d),
        .q_o      (exmem_q)
    );

    ctrl_stage_reg #(
        .Width ($bits(memwb_t))
    ) u_memwb (
        .clk_i    (Clk),
        .rst_ni   (Rst),
        .bubble_i (1'b0),
        .d_i      (memwb_d),
        .q_o      (memwb_q)
    );

    always_comb begin
        retired_d = retired_q;
        bubbles_d = bubbles_q;
        if (memwb_q.valid && (retired_q != CntMax)) begin
            retired_d = retired_q + CNT_W'(1);
        end
        if (bubble_cycle && (bubbles_q != CntMax)) begin
            bubbles_d = bubbles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            retired_q <= '0;
            bubbles_q <= '0;
        end else begin
            retired_q <= retired_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign EX_Ctrl   = idex_q.ex;
    assign M_Ctrl    = exmem_q.m;
    assign WB_Ctrl   = memwb_q.wb;
    assign EX_Valid  = idex_q.valid;
    assign MEM_Valid = exmem_q.valid;
    assign WB_Valid  = memwb_q.valid;
    assign Retired   = retired_q;
    assign Bubbles   = bubbles_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [8:0]  EX_In;
    logic [4:0]  M_In;
    logic [3:0]  WB_In;
    logic        Valid_In, Stall, Flush;
    logic [8:0]  EX_Ctrl;
    logic [4:0]  M_Ctrl;
    logic [3:0]  WB_Ctrl;
    logic        EX_Valid, MEM_Valid, WB_Valid;
    logic [15:0] Retired, Bubbles;

    int checks = 0;
    int errors = 0;

    ctrl_pipe dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .EX_In     (EX_In),
        .M_In      (M_In),
        .WB_In     (WB_In),
        .Valid_In  (Valid_In),
        .Stall     (Stall),
        .Flush     (Flush),
        .EX_Ctrl   (EX_Ctrl),
        .M_Ctrl    (M_Ctrl),
        .WB_Ctrl   (WB_Ctrl),
        .EX_Valid  (EX_Valid),
        .MEM_Valid (MEM_Valid),
        .WB_Valid  (WB_Valid),
        .Retired   (Retired),
        .Bubbles   (Bubbles)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [8:0]  ex;
        logic [4:0]  m;
        logic [3:0]  wb;
        logic        v, st, fl;
        logic [8:0]  e_ex;
        logic [4:0]  e_m;
        logic [3:0]  e_wb;
        logic        e_exv, e_memv, e_wbv;
        logic [15:0] e_ret, e_bub;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic [8:0] ex, logic [4:0] m, logic [3:0] wb,
                                logic v, logic st, logic fl,
                                logic [8:0] e_ex, logic [4:0] e_m, logic [3:0] e_wb,
                                logic e_exv, logic e_memv, logic e_wbv,
                                logic [15:0] e_ret, logic [15:0] e_bub);
        vec_t r;
        r.ex = ex; r.m = m; r.wb = wb; r.v = v; r.st = st; r.fl = fl;
        r.e_ex = e_ex; r.e_m = e_m; r.e_wb = e_wb;
        r.e_exv = e_exv; r.e_memv = e_memv; r.e_wbv = e_wbv;
        r.e_ret = e_ret; r.e_bub = e_bub;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [8:0] ex, input logic [4:0] m, input logic [3:0] wb,
                         input logic v, input logic st, input logic fl);
        EX_In = ex; M_In = m; WB_In = wb; Valid_In = v; Stall = st; Flush = fl;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [8:0] e_ex, input logic [4:0] e_m,
                           input logic [3:0] e_wb, input logic e_exv, input logic e_memv,
                           input logic e_wbv, input logic [15:0] e_ret,
                           input logic [15:0] e_bub);
        chk({tag, ".EX_Ctrl"},   32'(EX_Ctrl),   32'(e_ex));
        chk({tag, ".M_Ctrl"},    32'(M_Ctrl),    32'(e_m));
        chk({tag, ".WB_Ctrl"},   32'(WB_Ctrl),   32'(e_wb));
        chk({tag, ".EX_Valid"},  32'(EX_Valid),  32'(e_exv));
        chk({tag, ".MEM_Valid"}, 32'(MEM_Valid), 32'(e_memv));
        chk({tag, ".WB_Valid"},  32'(WB_Valid),  32'(e_wbv));
        chk({tag, ".Retired"},   32'(Retired),   32'(e_ret));
        chk({tag, ".Bubbles"},   32'(Bubbles),   32'(e_bub));
    endtask

    initial begin
        //               inputs ex   m     wb   v st fl | EX     M     WB   exv mv wv ret bub
        vecs[0]  = mk(9'h1A5, 5'h12, 4'hA, 1, 0, 0, 9'h1A5, 5'h00, 4'h0, 1, 0, 0, 0, 0);
        vecs[1]  = mk(9'h000, 5'h00, 4'h0, 0, 0, 0, 9'h000, 5'h12, 4'h0, 0, 1, 0, 0, 0);
        vecs[2]  = mk(9'h000, 5'h00, 4'h0, 0, 0, 0, 9'h000, 5'h00, 4'hA, 0, 0, 1, 0, 0);
        vecs[3]  = mk(9'h000, 5'h00, 4'h0, 0, 0, 0, 9'h000, 5'h00, 4'h0, 0, 0, 0, 1, 0);
        // invalid but non-zero bundle travels without counting as a bubble
        vecs[4]  = mk(9'h0F0, 5'h05, 4'h3, 0, 0, 0, 9'h0F0, 5'h00, 4'h0, 0, 0, 0, 1, 0);
        vecs[5]  = mk(9'h111, 5'h01, 4'h1, 1, 0, 0, 9'h111, 5'h05, 4'h0, 1, 0, 0, 1, 0);
        vecs[6]  = mk(9'h122, 5'h02, 4'h2, 1, 0, 0, 9'h122, 5'h01, 4'h3, 1, 1, 0, 1, 0);
        // two-cycle stall
        vecs[7]  = mk(9'h133, 5'h03, 4'h4, 1, 1, 0, 9'h000, 5'h02, 4'h1, 0, 1, 1, 1, 1);
        vecs[8]  = mk(9'h133, 5'h03, 4'h4, 1, 1, 0, 9'h000, 5'h00, 4'h2, 0, 0, 1, 2, 2);
        vecs[9]  = mk(9'h133, 5'h03, 4'h4, 1, 0, 0, 9'h133, 5'h00, 4'h0, 1, 0, 0, 3, 2);
        vecs[10] = mk(9'h144, 5'h04, 4'h5, 1, 0, 0, 9'h144, 5'h03, 4'h0, 1, 1, 0, 3, 2);
        vecs[11] = mk(9'h155, 5'h05, 4'h6, 1, 0, 0, 9'h155, 5'h04, 4'h4, 1, 1, 1, 3, 2);
        // flush with three in flight: only the MEM/WB one survives
        vecs[12] = mk(9'h166, 5'h06, 4'h7, 1, 0, 1, 9'h000, 5'h00, 4'h5, 0, 0, 1, 4, 3);
        vecs[13] = mk(9'h000, 5'h00, 4'h0, 0, 0, 0, 9'h000, 5'h00, 4'h0, 0, 0, 0, 5, 3);
        vecs[14] = mk(9'h177, 5'h07, 4'h8, 1, 0, 0, 9'h177, 5'h00, 4'h0, 1, 0, 0, 5, 3);
        // stall and flush together: flush result, one bubble
        vecs[15] = mk(9'h188, 5'h08, 4'h9, 1, 1, 1, 9'h000, 5'h00, 4'h0, 0, 0, 0, 5, 4);
        vecs[16] = mk(9'h000, 5'h00, 4'h0, 0, 0, 0, 9'h000, 5'h00, 4'h0, 0, 0, 0, 5, 4);

        // Reset with every other input asserted must still clear everything.
        Rst = 1'b0;
        drive(9'h1FF, 5'h1F, 4'hF, 1, 1, 1);
        tick();
        tick();
        chk_all("reset", 9'h0, 5'h0, 4'h0, 0, 0, 0, 16'h0, 16'h0);

        Rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].ex, vecs[i].m, vecs[i].wb, vecs[i].v, vecs[i].st, vecs[i].fl);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_ex, vecs[i].e_m, vecs[i].e_wb,
                    vecs[i].e_exv, vecs[i].e_memv, vecs[i].e_wbv, vecs[i].e_ret,
                    vecs[i].e_bub);
        end

        // Mid-stream reset: fill the pipe, then reset while stalling/flushing.
        drive(9'h0AA, 5'h0A, 4'h5, 1, 0, 0);
        tick();
        tick();
        tick();
        tick();
        chk("pre_rst.Retired", 32'(Retired), 32'd6);
        Rst = 1'b0;
        drive(9'h055, 5'h15, 4'hC, 1, 1, 1);
        tick();
        chk_all("mid_rst", 9'h0, 5'h0, 4'h0, 0, 0, 0, 16'h0, 16'h0);
        Rst = 1'b1;
        drive(9'h0C3, 5'h0E, 4'h6, 1, 0, 0);
        tick();
        chk_all("post_rst", 9'h0C3, 5'h00, 4'h0, 1, 0, 0, 16'h0, 16'h0);

        // Saturation: continuous valid stream; after N edges from an empty pipe Retired = N-3.
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        drive(9'h001, 5'h01, 4'h1, 1, 0, 0);
        for (int i = 0; i < 65537; i++) begin
            tick();
        end
        chk("sat.Retired_fffe", 32'(Retired), 32'hFFFE);
        tick();
        chk("sat.Retired_ffff", 32'(Retired), 32'hFFFF);
        tick();
        chk("sat.Retired_hold1", 32'(Retired), 32'hFFFF);
        tick();
        chk("sat.Retired_hold2", 32'(Retired), 32'hFFFF);
        chk("sat.Bubbles", 32'(Bubbles), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
